// File: rtl/fifo_ptr_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : fifo_ptr_ctrl_if
// Purpose  : Bundles the pointer-controller signals exchanged with the FIFO RAM
//            address port and the opposite-side controller.
// Signals  : en     - increment request (write or read strobe)
//            rmt_g  - remote side's Gray pointer (ADDR_W+1 bits)
//            addr   - RAM address (ADDR_W bits)
//            ptr_g  - local registered Gray pointer (ADDR_W+1 bits)
//            stat   - full (write side) or empty (read side)
//            level  - occupied entries (ADDR_W+1 bits)
//            thr    - level threshold flag
// Modports : slave  - the pointer controller itself
//            master - whatever drives en/rmt_g and consumes the results
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fifo_ptr_ctrl_if #(
  parameter int ADDR_W = 3
) ();
  logic              en;
  logic [ADDR_W:0]   rmt_g;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   ptr_g;
  logic              stat;
  logic [ADDR_W:0]   level;
  logic              thr;

  modport slave  (input  en, rmt_g, output addr, ptr_g, stat, level, thr);
  modport master (output en, rmt_g, input  addr, ptr_g, stat, level, thr);
endinterface

`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
//------------------------------------------------------------------------------
// Module   : fifo_ptr_ctrl
// Purpose  : FIFO pointer controller for one side (write or read) of a FIFO.
//            Keeps an (ADDR_W+1)-bit binary pointer and a Gray copy, brings in
//            the remote Gray pointer, and produces registered full/empty,
//            fill level and threshold flags.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - fifo_ptr_ctrl_if.slave (en, rmt_g in; addr, ptr_g, stat,
//                   level, thr out)
// Params   : ADDR_W (RAM address width), MODE (0 write/full, 1 read/empty),
//            SYNC_STAGES (2..4 remote-pointer flops), THRESH (level threshold)
// Options  : PTR_SYNC_EN - when defined, rmt_g passes through SYNC_STAGES
//            reset-to-zero flops before use; otherwise it is used directly
//            (same-clock FIFO).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_ptr_ctrl #(
  parameter int ADDR_W      = 3,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int THRESH      = 6
) (
  input  logic          clk,
  input  logic          rst,
  fifo_ptr_ctrl_if.slave bus
);

  localparam int              PW       = ADDR_W + 1;
  localparam logic [ADDR_W:0] THR_LVL  = PW'(THRESH);
  localparam logic            STAT_RST = (MODE != 0);
  // Level is 0 in reset, so the threshold flag starts at the comparison of 0.
  localparam logic            THR_RST  = (MODE != 0) ? (THRESH >= 0) : (THRESH <= 0);

  logic [ADDR_W:0] ptr_b;
  logic [ADDR_W:0] ptr_g;
  logic [ADDR_W:0] nxt_b;
  logic [ADDR_W:0] nxt_g;
  logic [ADDR_W:0] rs_g;
  logic [ADDR_W:0] rs_b;
  logic [ADDR_W:0] nxt_lvl;
  logic [ADDR_W:0] level;
  logic            stat;
  logic            thr;
  logic            inc;
  logic            nxt_stat;
  logic            nxt_thr;

  // Out-of-range depth has no meaningful chain; leave an empty marker scope.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_sync_stages_illegal
  end

  //--------------------------------------------------------------------------
  // Remote pointer capture
  //--------------------------------------------------------------------------
`ifdef PTR_SYNC_EN
  logic [ADDR_W:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.rmt_g;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rs_g = sync_q[SYNC_STAGES-1];
`else
  assign rs_g = bus.rmt_g;
`endif

  // Gray to binary: bit i is the XOR of all Gray bits from i upward.
  always_comb begin
    rs_b = '0;
    for (int i = 0; i <= ADDR_W; i++) rs_b[i] = ^(rs_g >> i);
  end

  //--------------------------------------------------------------------------
  // Next pointer
  //--------------------------------------------------------------------------
  assign inc   = bus.en & ~stat;           // strobe ignored while full/empty
  assign nxt_b = ptr_b + PW'(inc);         // wraps modulo 2**(ADDR_W+1)
  assign nxt_g = nxt_b ^ (nxt_b >> 1);

  //--------------------------------------------------------------------------
  // Side-specific flag and level
  //--------------------------------------------------------------------------
  if (MODE == 0) begin : g_wr
    logic [ADDR_W:0] full_g;
    // Full when the write pointer is one lap ahead: in Gray code that is the
    // top two bits inverted and the rest equal.
    if (ADDR_W == 1) begin : g_full_w1
      assign full_g = ~rs_g[1:0];
    end else begin : g_full_wn
      assign full_g = {~rs_g[ADDR_W:ADDR_W-1], rs_g[ADDR_W-2:0]};
    end
    assign nxt_stat = (nxt_g == full_g);
    assign nxt_lvl  = nxt_b - rs_b;
    assign nxt_thr  = (nxt_lvl >= THR_LVL);
  end else begin : g_rd
    assign nxt_stat = (nxt_g == rs_g);
    assign nxt_lvl  = rs_b - nxt_b;
    assign nxt_thr  = (nxt_lvl <= THR_LVL);
  end

  //--------------------------------------------------------------------------
  // State registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_b <= '0;
      ptr_g <= '0;
      stat  <= STAT_RST;
      level <= '0;
      thr   <= THR_RST;
    end else begin
      ptr_b <= nxt_b;
      ptr_g <= nxt_g;
      stat  <= nxt_stat;
      level <= nxt_lvl;
      thr   <= nxt_thr;
    end
  end

  assign bus.addr  = ptr_b[ADDR_W-1:0];
  assign bus.ptr_g = ptr_g;
  assign bus.stat  = stat;
  assign bus.level = level;
  assign bus.thr   = thr;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ptr_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo_ptr_ctrl
// Purpose  : Self-checking bench for fifo_ptr_ctrl. One write-side (MODE 0) and
//            one read-side (MODE 1) instance, each with its own interface and
//            independently driven remote pointer. Directed stimulus pushes the
//            expected outputs into a queue; a monitor pops and compares them
//            one clock later.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_ptr_ctrl;

`ifdef PTR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [2:0] addr;
    logic [3:0] ptr_g;
    logic       stat;
    logic [3:0] level;
    logic       thr;
  } obs_t;

  typedef struct {
    int    cyc;
    int    dut;
    string name;
    obs_t  exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic [3:0] wrmt = 4'd0;
  logic [3:0] rrmt = 4'd0;

  int   cycle  = 0;
  int   passed = 0;
  int   total  = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  fifo_ptr_ctrl_if #(.ADDR_W(3)) wif ();
  fifo_ptr_ctrl_if #(.ADDR_W(3)) rif ();

  assign wif.en    = wen;
  assign wif.rmt_g = wrmt;
  assign rif.en    = ren;
  assign rif.rmt_g = rrmt;

  fifo_ptr_ctrl #(.ADDR_W(3), .MODE(0), .SYNC_STAGES(2), .THRESH(6)) u_wr (
    .clk (clk),
    .rst (rst),
    .bus (wif)
  );

  fifo_ptr_ctrl #(.ADDR_W(3), .MODE(1), .SYNC_STAGES(2), .THRESH(6)) u_rd (
    .clk (clk),
    .rst (rst),
    .bus (rif)
  );

  function automatic logic [3:0] gr(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  // Expected outputs for binary pointer p.
  function automatic obs_t ob(input int p, input logic s, input int l, input logic t);
    obs_t o;
    o.addr  = 3'(p);
    o.ptr_g = gr(p);
    o.stat  = s;
    o.level = 4'(l);
    o.thr   = t;
    return o;
  endfunction

  task automatic chk(input string nm, input string f, input int a, input int x);
    total++;
    if (a == x) passed++;
    else $display("FAIL %s.%s: got %0d expected %0d (cycle %0d)", nm, f, a, x, cycle);
  endtask

  // Monitor: compare every expectation due at this cycle.
  initial begin
    exp_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      while (q.size() > 0 && q[0].cyc <= cycle) begin
        e = q.pop_front();
        if (e.cyc < cycle) begin
          total++;
          $display("FAIL %s: expectation for cycle %0d not checked", e.name, e.cyc);
        end else begin
          a = (e.dut == 0) ? obs_t'{wif.addr, wif.ptr_g, wif.stat, wif.level, wif.thr}
                           : obs_t'{rif.addr, rif.ptr_g, rif.stat, rif.level, rif.thr};
          chk(e.name, "addr",  int'(a.addr),  int'(e.exp.addr));
          chk(e.name, "ptr_g", int'(a.ptr_g), int'(e.exp.ptr_g));
          chk(e.name, "stat",  int'(a.stat),  int'(e.exp.stat));
          chk(e.name, "level", int'(a.level), int'(e.exp.level));
          chk(e.name, "thr",   int'(a.thr),   int'(e.exp.thr));
        end
      end
    end
  end

  // One clock of stimulus; ex is the state expected after the coming edge.
  task automatic step(input int dut, input string name, input logic r, input logic e,
                      input logic [3:0] rm, input obs_t ex);
    exp_t it;
    @(negedge clk);
    rst = r;
    if (dut == 0) begin
      wen  = e;
      wrmt = rm;
    end else begin
      ren  = e;
      rrmt = rm;
    end
    it.cyc  = cycle + 1;
    it.dut  = dut;
    it.name = name;
    it.exp  = ex;
    q.push_back(it);
  endtask

  // Remote pointer change: outputs hold for the sync latency, then update.
  task automatic remote(input int dut, input string name, input logic [3:0] rm,
                        input obs_t old_o, input obs_t new_o);
    for (int k = 0; k < LAT; k++) step(dut, name, 1'b0, 1'b0, rm, old_o);
    step(dut, name, 1'b0, 1'b0, rm, new_o);
  endtask

  initial begin
    // Write side: fill from reset to full; threshold from the 6th write.
    step(0, "t1_rst", 1'b1, 1'b0, 4'd0, ob(0, 1'b0, 0, 1'b0));
    for (int k = 1; k <= 8; k++)
      step(0, "t1_fill", 1'b0, 1'b1, 4'd0, ob(k, k == 8, k, k >= 6));

    // Writes while full are ignored; one remote read clears full.
    for (int k = 0; k < 3; k++)
      step(0, "t2_hold", 1'b0, 1'b1, 4'd0, ob(8, 1'b1, 8, 1'b1));
    remote(0, "t2_drain", gr(1), ob(8, 1'b1, 8, 1'b1), ob(8, 1'b0, 7, 1'b0 | 1'b1));

    // Wrap: alternate write (goes full) and remote advance (level 7).
    for (int i = 0; i < 8; i++) begin
      step(0, "t5_wrap_wr", 1'b0, 1'b1, gr(1 + i), ob((9 + i) % 16, 1'b1, 8, 1'b1));
      remote(0, "t5_wrap_rmt", gr(2 + i), ob((9 + i) % 16, 1'b1, 8, 1'b1),
             ob((9 + i) % 16, 1'b0, 7, 1'b1));
    end

    // Reset in the middle of a burst at ptr_b = 5.
    step(0, "t6_rst", 1'b1, 1'b0, 4'd0, ob(0, 1'b0, 0, 1'b0));
    for (int k = 1; k <= 5; k++)
      step(0, "t6_burst", 1'b0, 1'b1, 4'd0, ob(k, 1'b0, k, 1'b0));
    step(0, "t6_midrst", 1'b1, 1'b1, 4'd0, ob(0, 1'b0, 0, 1'b0));
    step(0, "t6_after",  1'b0, 1'b0, 4'd0, ob(0, 1'b0, 0, 1'b0));

    // Read side: empty after reset, reads ignored, remote write of 3 entries.
    step(1, "t3_rst", 1'b1, 1'b0, 4'd0, ob(0, 1'b1, 0, 1'b1));
    step(1, "t3_ign", 1'b0, 1'b1, 4'd0, ob(0, 1'b1, 0, 1'b1));
    remote(1, "t3_rmt", gr(3), ob(0, 1'b1, 0, 1'b1), ob(0, 1'b0, 3, 1'b1));
    step(1, "t3_rd",      1'b0, 1'b1, gr(3), ob(1, 1'b0, 2, 1'b1));
    step(1, "t3_rd",      1'b0, 1'b1, gr(3), ob(2, 1'b0, 1, 1'b1));
    step(1, "t3_rd",      1'b0, 1'b1, gr(3), ob(3, 1'b1, 0, 1'b1));
    step(1, "t3_emp_ign", 1'b0, 1'b1, gr(3), ob(3, 1'b1, 0, 1'b1));

    // Read side: single remote step clears empty, one read sets it again,
    // then the level climbs past the threshold.
    step(1, "t4_rst", 1'b1, 1'b0, 4'd0, ob(0, 1'b1, 0, 1'b1));
    remote(1, "t4_rmt", gr(1), ob(0, 1'b1, 0, 1'b1), ob(0, 1'b0, 1, 1'b1));
    step(1, "t4_rd", 1'b0, 1'b1, gr(1), ob(1, 1'b1, 0, 1'b1));
    for (int b = 2; b <= 8; b++)
      remote(1, "t4_lvl", gr(b),
             (b == 2) ? ob(1, 1'b1, 0, 1'b1) : ob(1, 1'b0, b - 2, 1'b1),
             ob(1, 1'b0, b - 1, (b - 1) <= 6));
    ren = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && q.size() > 0; w++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
